// File: rtl/aes_stream_pkg.sv
// Shared widths, pipeline latency and block type for the AES stream controller.
// Word slot 0 is the most significant 32 bits of a block.
package aes_stream_pkg;

  localparam int BLOCK_W          = 128;
  localparam int WORD_W           = 32;
  localparam int WORDS_PER_BLK    = 4;
  localparam int AES_PIPE_LATENCY = 15;

  typedef logic [BLOCK_W-1:0] aes_block_t;

  // MSB index of word slot idx within a block (slot 0 -> bit 127).
  function automatic int word_msb(input logic [1:0] idx);
    return BLOCK_W - 1 - WORD_W * int'(idx);
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Word-stream interface of the AES stream controller: key words in, result words out.
// Both directions: a word transfers on a rising edge where valid & ready are high;
// the source holds valid and data stable until that edge, and ready may depend on state only.
interface aes_stream_ctrl_if;
  import aes_stream_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/aes_blk_fifo.sv
// DEPTH-entry synchronous FIFO of 128-bit result blocks, async active-low reset.
// Push and pop on the same edge are both performed and leave count unchanged.
module aes_blk_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  aes_block_t    push_data,
  input  logic          pop,
  output aes_block_t    head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  aes_block_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // The upstream credit scheme must make these impossible.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CW'(DEPTH)));
  underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule

// File: rtl/aes_stream_ctrl.sv
// Stream front/back-end for a free-running LATENCY-stage AES pipeline with credit-gated issue.
// Optional perf counters (perf_blocks, perf_stall) are built when AES_STREAM_PERF_EN is defined.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int LATENCY = AES_PIPE_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_stream_ctrl_if.slave  strm,
  output aes_block_t        pipe_key,
  input  aes_block_t        pipe_out,
  output logic              busy
`ifdef AES_STREAM_PERF_EN
  ,
  output logic [31:0]       perf_blocks,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]         wcnt;
  aes_block_t         asm_blk;
  logic               blk_full;
  logic               accept;
  logic               has_credit;
  logic               issue;
  logic               stall;
  logic [LATENCY-1:0] vsr;
  logic               capture;
  logic [CW-1:0]      in_flight;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  aes_block_t         head;
  logic [1:0]         rcnt;
  logic               load;
  logic               pop;
  logic               out_valid_q;
  logic [WORD_W-1:0]  out_data_q;
  logic               out_last_q;

  // Credits count blocks already committed to the buffer: in flight plus buffered.
  assign accept     = strm.in_valid & strm.in_ready;
  assign has_credit = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
  assign issue      = blk_full & has_credit;
  assign stall      = blk_full & ~has_credit;
  assign strm.in_ready = ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      asm_blk  <= '0;
      blk_full <= 1'b0;
      pipe_key <= '0;
    end else begin
      if (accept) begin
        asm_blk[word_msb(wcnt) -: WORD_W] <= strm.in_data;
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'(WORDS_PER_BLK - 1)) blk_full <= 1'b1;
      end
      // Slot 0 of the next block may be written on this same edge; pipe_key takes the old block.
      if (issue) begin
        pipe_key <= asm_blk;
        blk_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsr <= '0;
    else        vsr <= {vsr[LATENCY-2:0], issue};
  end

  assign capture = vsr[LATENCY-1];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++) in_flight = in_flight + CW'(vsr[i]);
  end

  aes_blk_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (pipe_out),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // rcnt selects the next head word to move into the output register; the head
  // leaves the buffer as its last word is loaded, so at most one word sits outside it.
  assign load = ~fifo_empty & (~out_valid_q | strm.out_ready);
  assign pop  = load & (rcnt == 2'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= head[word_msb(rcnt) -: WORD_W];
      out_last_q  <= (rcnt == 2'(WORDS_PER_BLK - 1));
      rcnt        <= rcnt + 2'd1;
    end else if (strm.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;

  assign busy = blk_full | (wcnt != 2'd0) | (|vsr) | ~fifo_empty | out_valid_q;

`ifdef AES_STREAM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      perf_blocks <= perf_blocks + 32'(issue);
      perf_stall  <= perf_stall + 32'(stall);
    end
  end
`endif

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Streaming front/back-end for the free-running 15-stage AES round pipeline.
- Upstream side: assembles 32-bit key words from a valid/ready stream into 128-bit blocks and drives them into the pipeline's key input.
- Downstream side: tracks each issued block through the pipeline latency, captures the pipeline result, buffers it, and serializes it as 32-bit words with valid/ready.
- The pipeline cannot stall, so issue is credit-gated against the output buffer.

Parameters:
- LATENCY, 15, clock cycles from `pipe_key` change to matching `pipe_out`.
- DEPTH, 4, output buffer entries (128-bit each); also the credit limit.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  32  key word; first word of a block -> key[127:96], last word -> key[31:0].
- pipe_key  out  128  key driven to the round pipeline (registered).
- pipe_out  in  128  pipeline result.
- out_valid  out  1  output word valid.
- out_ready  in  1  output word consumed when out_valid & out_ready.
- out_data  out  32  result word; first word is out[127:96].
- out_last  out  1  high with the 4th word of each block.
- busy  out  1  high when any block is being assembled, in flight, or buffered.

Behaviour:
- Reset values: in_ready=1, pipe_key=0, out_valid=0, out_data=0, out_last=0, busy=0. Assembly, word counters, valid shift register and buffer are all cleared.
- Assembler:
  - 2-bit word counter wcnt.
  - On accept: the word is written into slot wcnt and wcnt increments.
  - On the 4th accept the block is complete.
- Issue:
  - A complete block issues on the cycle after the 4th accept, provided credits allow.
  - credits = DEPTH - (in_flight + fifo_count). Issue requires credits >= 1.
  - On issue, pipe_key <= assembled block and bit 0 of the LATENCY-long valid shift register is set for that cycle.
  - While a complete block waits for credit: in_ready=0 and pipe_key holds its previous value.
  - in_ready=1 otherwise. A new block's first word may be accepted on the issue cycle.
- Tracking:
  - The valid shift register advances every cycle.
  - When bit LATENCY-1 is set, pipe_out is written into the buffer on that edge.
  - in_flight = popcount of the shift register.
  - Issue order equals capture order. No reordering.
- Buffer:
  - FIFO, DEPTH entries.
  - Credit gating guarantees it never overflows. Overflow is an assertion failure, not a handled case.
  - A capture and a pop on the same cycle are both performed; the count is unchanged.
- Serializer:
  - 2-bit rcnt.
  - out_data = head[127-32*rcnt -: 32], registered.
  - out_valid is high while the buffer is non-empty.
  - On handshake rcnt increments. When rcnt=3 the head is popped and out_last=1 for that word.
  - out_data/out_valid hold stable while out_ready=0.
- Simultaneous events:
  - Issue and capture on the same cycle is allowed. The credit check uses pre-edge counts, with capture not crediting.
  - Capture on the cycle the last word pops: count is unchanged.
- Reset mid-operation: the partial block, in-flight tags and buffered data are discarded. Pipeline contents still flow out but are untagged and ignored.
- Width rules: counters are sized with $clog2(DEPTH+1). No arithmetic on data.

Optional Feature:
- Macro: AES_STREAM_PERF_EN.
- Defined: adds two outputs, both reset to 0 and wrapping modulo 2^32.
  - perf_blocks (32): count of issued blocks.
  - perf_stall (32): cycles a complete block waited for credit.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package aes_stream_pkg holds:
  - BLOCK_W=128, WORD_W=32, WORDS_PER_BLK=4.
  - AES_PIPE_LATENCY=15.
  - typedef aes_block_t (logic [127:0]).
- One sub-module, aes_blk_fifo: DEPTH-parameterized 128-bit synchronous FIFO with async active-low reset, push/pop/count/empty.

Test Plan:
- Single block: words 32'h00010203, 04050607, 08090a0b, 0c0d0e0f with out_ready=1 -> pipe_key=128'h000102030405060708090a0b0c0d0e0f one cycle after the 4th accept. First out word appears LATENCY+1 cycles after issue, matches the reference model output[127:96], and out_last is high on the 4th word.
- Backpressure: out_ready=0, feed 6 blocks back-to-back -> exactly 4 issue. in_ready drops during block 5 completion and perf_stall increments each cycle. Releasing out_ready drains the buffer in order and blocks 5-6 then issue.
- Throughput: out_ready=1, continuous input -> one issue every 4 cycles. in_ready never low after the first block. Results are in order.
- Out_ready toggled every other cycle -> out_data is stable while stalled, with no word lost or duplicated across 3 blocks.
- Reset mid-flight: assert rst_n=0 for 2 cycles while 2 blocks are in flight and 1 is buffered -> all outputs return to reset values. No stale output appears during the following LATENCY+4 cycles.
- Capture/pop coincidence: time the 4th-word pop on the same cycle as a capture -> count is unchanged and the next block serializes correctly.
